// File: rtl/omem_potential_store_if.sv
// omem_potential_store_if: request/reply packet bus between the mesh and the output memory.
interface omem_potential_store_if;
   logic        in_valid;
   logic        in_ready;
   logic [29:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [29:0] out_data;
   modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
   modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/omem_potential_store.sv
// omem_potential_store: per-neuron potential/spike store serving sum-PE reads and counting timesteps.
module omem_potential_store #(
   parameter int OMEM_ID     = 10,
   parameter int SUM_WIDTH   = 13,
   parameter int FILTER_SIZE = 5,
   parameter int IFMAP_SIZE  = 25
) (
   input  logic                clk,
   input  logic                reset,
   omem_potential_store_if.slave bus,
   input  logic [8:0]          spike_rd_idx,
   output logic                spike_rd_bit,
   output logic [3:0]          timestep,
   output logic                ts_done,
   output logic [1:0]          err_flags
);
   localparam int OUTPUT_DIM  = IFMAP_SIZE - FILTER_SIZE + 1;
   localparam int NUM_NEURONS = OUTPUT_DIM * OUTPUT_DIM;
   localparam logic [8:0] LAST = 9'(NUM_NEURONS - 1);
   typedef enum logic [1:0] {IDLE, RD, RESP} state_t;
   state_t state, nxt;
   logic [SUM_WIDTH-1:0] pot [NUM_NEURONS];
   logic [NUM_NEURONS-1:0] spk, vld;
   logic [SUM_WIDTH-1:0] rd_q;
   logic [8:0] rd_idx, wcnt;
   logic [3:0] rd_dest;
   logic hit;
   logic [3:0] dest;
   logic [8:0] idx;
   logic op, acc, routed, in_range, wr, rd;
   wire unused_bits = ^bus.in_data[15:14];
   assign dest     = bus.in_data[29:26];
   assign op       = bus.in_data[25];
   assign idx      = bus.in_data[24:16];
   assign acc      = bus.in_valid & bus.in_ready;
   assign routed   = dest == 4'(OMEM_ID);
   assign in_range = idx < 9'(NUM_NEURONS);
   assign wr       = acc & routed & ~op & in_range;
   assign rd       = acc & routed & op;
   assign bus.in_ready  = state == IDLE;
   assign bus.out_valid = state == RESP;
   // Reply is formed from registered read results, so it is stable for the whole RESP stall.
   assign bus.out_data  = state == RESP ? {rd_dest, 1'b1, hit ? 25'(rd_q) : 25'd0} : 30'd0;
   always_comb begin
      nxt = state == IDLE ? (rd ? RD : IDLE) : state == RD ? RESP : (bus.out_ready ? IDLE : RESP);
   end
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nxt;
   end
   always_ff @(posedge clk) begin
      if (wr) begin
         pot[idx] <= bus.in_data[SUM_WIDTH-1:0];
         spk[idx] <= bus.in_data[13];
      end
      if (rd) begin
         rd_idx  <= idx;
         rd_dest <= bus.in_data[3:0];
      end
      if (state == RD) begin
         rd_q <= pot[rd_idx];
         hit  <= rd_idx < 9'(NUM_NEURONS) && vld[rd_idx];
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         vld          <= '0;
         wcnt         <= '0;
         timestep     <= '0;
         ts_done      <= 1'b0;
         err_flags    <= '0;
         spike_rd_bit <= 1'b0;
      end else begin
         ts_done      <= wr && wcnt == LAST;
         spike_rd_bit <= spike_rd_idx < 9'(NUM_NEURONS) && vld[spike_rd_idx] && spk[spike_rd_idx];
         if (wr) begin
            vld[idx] <= 1'b1;
            wcnt     <= wcnt == LAST ? 9'd0 : wcnt + 9'd1;
            if (wcnt == LAST) timestep <= timestep + 4'd1;
         end
         if (acc && !routed) err_flags[0] <= 1'b1;
         if (acc && routed && !in_range) err_flags[1] <= 1'b1;
      end
   end
endmodule

// File: tb/tb_omem_potential_store.sv
// tb_omem_potential_store: directed vector table plus hand sequences for stall, timestep wrap and reset.
module tb_omem_potential_store;
   logic clk = 0;
   logic reset = 1;
   logic [8:0] spike_rd_idx = 0;
   logic spike_rd_bit, ts_done;
   logic [3:0] timestep;
   logic [1:0] err_flags;
   int errors = 0, checks = 0;
   localparam logic [3:0] ID = 4'd10;
   always #5 clk = ~clk;
   omem_potential_store_if bus();
   omem_potential_store dut (
      .clk(clk), .reset(reset), .bus(bus), .spike_rd_idx(spike_rd_idx),
      .spike_rd_bit(spike_rd_bit), .timestep(timestep), .ts_done(ts_done), .err_flags(err_flags)
   );
   typedef struct {
      logic       rd;
      logic [8:0] idx;
      logic       spk;
      logic [12:0] pot;
      logic [1:0] x;
      logic [3:0] rdest;
   } vec_t;
   vec_t tv [8];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   function automatic logic [29:0] wpkt(input logic [3:0] d, input logic [8:0] i, input logic s,
                                        input logic [12:0] p, input logic [1:0] x);
      return {d, 1'b0, i, x, s, p};
   endfunction
   function automatic logic [29:0] rpkt(input logic [3:0] d, input logic [8:0] i, input logic [3:0] r);
      return {d, 1'b1, i, 12'h0, r};
   endfunction
   task automatic send(input logic [29:0] p);
      int n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", 32'(bus.in_ready), 1);
      bus.in_valid = 1;
      bus.in_data  = p;
      @(negedge clk);
      bus.in_valid = 0;
   endtask
   task automatic do_read(input string nm, input logic [8:0] i, input logic [3:0] r, input logic [12:0] e);
      send(rpkt(ID, i, r));
      chk({nm, "_lat1_valid"}, 32'(bus.out_valid), 0);
      chk({nm, "_rd_ready"}, 32'(bus.in_ready), 0);
      @(negedge clk);
      chk({nm, "_valid"}, 32'(bus.out_valid), 1);
      chk({nm, "_data"}, 32'(bus.out_data), 32'({r, 1'b1, 12'h0, e}));
      bus.out_ready = 1;
      @(negedge clk);
      bus.out_ready = 0;
      chk({nm, "_done_valid"}, 32'(bus.out_valid), 0);
      chk({nm, "_idle_ready"}, 32'(bus.in_ready), 1);
   endtask
   task automatic do_reset();
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int ts_seen;
      logic rdy_ok;
      bus.in_valid = 0;
      bus.in_data = 0;
      bus.out_ready = 0;
      tv[0] = '{0, 9'd7,   0, 13'h0040, 2'b00, 4'd0};
      tv[1] = '{1, 9'd7,   0, 13'h0040, 2'b00, 4'd3};
      tv[2] = '{1, 9'd100, 0, 13'h0000, 2'b00, 4'd5};
      tv[3] = '{0, 9'd9,   1, 13'h1fff, 2'b00, 4'd0};
      tv[4] = '{1, 9'd9,   0, 13'h1fff, 2'b00, 4'd15};
      tv[5] = '{0, 9'd7,   0, 13'h0abc, 2'b11, 4'd0};
      tv[6] = '{1, 9'd7,   0, 13'h0abc, 2'b00, 4'd1};
      tv[7] = '{1, 9'd440, 0, 13'h0000, 2'b00, 4'd10};
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_data", 32'(bus.out_data), 0);
      chk("rst_timestep", 32'(timestep), 0);
      chk("rst_err", 32'(err_flags), 0);
      chk("rst_ts_done", 32'(ts_done), 0);
      reset = 0;
      @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 1);
      for (int k = 0; k < 8; k++) begin
         if (tv[k].rd) do_read($sformatf("vec%0d", k), tv[k].idx, tv[k].rdest, tv[k].pot);
         else send(wpkt(ID, tv[k].idx, tv[k].spk, tv[k].pot, tv[k].x));
      end
      chk("vec_err", 32'(err_flags), 0);
      spike_rd_idx = 9;
      @(negedge clk);
      chk("spike9", 32'(spike_rd_bit), 1);
      spike_rd_idx = 7;
      @(negedge clk);
      chk("spike7", 32'(spike_rd_bit), 0);
      spike_rd_idx = 100;
      @(negedge clk);
      chk("spike100", 32'(spike_rd_bit), 0);
      do_reset();
      send(wpkt(ID, 9'd500, 1'b0, 13'd5, 2'b00));
      chk("oor_wr_err", 32'(err_flags), 2);
      do_read("oor_rd", 9'd500, 4'd2, 13'd0);
      ts_seen = 0;
      rdy_ok = 1;
      for (int i = 0; i < 441; i++) begin
         if (!bus.in_ready) rdy_ok = 0;
         if (ts_done) ts_seen++;
         bus.in_valid = 1;
         bus.in_data  = wpkt(ID, 9'(i), i[0], 13'(i) ^ 13'h155, 2'b00);
         @(negedge clk);
      end
      bus.in_valid = 0;
      chk("b2b_ready", 32'(rdy_ok), 1);
      chk("b2b_early_ts", 32'(ts_seen), 0);
      chk("b2b_ts_done", 32'(ts_done), 1);
      chk("b2b_timestep", 32'(timestep), 1);
      @(negedge clk);
      chk("b2b_ts_pulse_end", 32'(ts_done), 0);
      do_read("b2b_rd1", 9'd1, 4'd4, 13'h154);
      send(rpkt(ID, 9'd0, 4'd6));
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         chk("stall_valid", 32'(bus.out_valid), 1);
         chk("stall_data", 32'(bus.out_data), 32'({4'd6, 1'b1, 12'h0, 13'h155}));
         chk("stall_ready", 32'(bus.in_ready), 0);
         @(negedge clk);
      end
      bus.out_ready = 1;
      @(negedge clk);
      bus.out_ready = 0;
      chk("stall_release", 32'(bus.out_valid), 0);
      chk("stall_idle", 32'(bus.in_ready), 1);
      send(wpkt(4'd4, 9'd3, 1'b0, 13'd1, 2'b00));
      chk("misroute_err", 32'(err_flags), 3);
      rdy_ok = 1;
      for (int c = 0; c < 3; c++) begin
         if (bus.out_valid || !bus.in_ready) rdy_ok = 0;
         @(negedge clk);
      end
      chk("misroute_no_reply", 32'(rdy_ok), 1);
      send(rpkt(ID, 9'd2, 4'd1));
      @(negedge clk);
      chk("rstresp_valid", 32'(bus.out_valid), 1);
      reset = 1;
      @(negedge clk);
      chk("rstresp_out_valid", 32'(bus.out_valid), 0);
      chk("rstresp_out_data", 32'(bus.out_data), 0);
      chk("rstresp_timestep", 32'(timestep), 0);
      chk("rstresp_err", 32'(err_flags), 0);
      chk("rstresp_spike", 32'(spike_rd_bit), 0);
      reset = 0;
      @(negedge clk);
      chk("rstresp_in_ready", 32'(bus.in_ready), 1);
      do_read("rstresp_cleared", 9'd0, 4'd7, 13'd0);
      spike_rd_idx = 1;
      @(negedge clk);
      chk("rstresp_spike_cleared", 32'(spike_rd_bit), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
